jump_predictor: RTL and testbench
=================================

# jump_predictor

Fetch-stage jump target predictor for the 3-stage RISC-V core, the parametrised successor to the combinational JAL/JALR target adder. It predicts JAL/JALR targets at fetch from a direct-mapped branch target buffer (BTB) and, optionally, a return address stack (RAS). At execute it computes the true target, flags mispredictions and trains its state. Fetch consumes `pred_*`; the hazard/redirect logic consumes `x_mispredict` and `x_target`.

## Interface
- `XLEN`, 32: datapath width.
- `BTB_ENTRIES`, 16: BTB depth; power of two, ≥2. IDX = log2(BTB_ENTRIES).
- `RAS_DEPTH`, 4: RAS depth; power of two, ≥2. Used only with `JUMP_PRED_RAS_EN`.

Ports:
- `clk`, input, 1: clock; all state updates on rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `f_pc`, input, XLEN: fetch PC.
- `pred_taken`, output, 1: predicted jump at `f_pc`.
- `pred_target`, output, XLEN: predicted target; 0 when `pred_taken`=0.
- `x_valid`, input, 1: a JAL/JALR is resolving in execute this cycle.
- `x_jop`, input, 1: 0 = JAL, 1 = JALR.
- `x_pc`, input, XLEN: PC of the resolving jump.
- `x_imm`, input, XLEN: sign-extended immediate.
- `x_rs1`, input, XLEN: forwarded rs1 value.
- `x_is_call`, input, 1: rd ∈ {x1, x5}.
- `x_is_ret`, input, 1: JALR with rs1 ∈ {x1, x5}, rd = x0.
- `x_pred_taken`, input, 1: the `pred_taken` carried down with this instruction.
- `x_pred_target`, input, XLEN: the `pred_target` carried down with this instruction.
- `x_target`, output, XLEN: resolved target.
- `x_mispredict`, output, 1: redirect required.

## Operation
- BTB entry fields: valid, tag = pc[XLEN-1:IDX+2], target[XLEN-1:1], is_ret.
- Index: pc[IDX+1:2].
- Lookup is combinational on `f_pc`. Hit means valid and tag match.
- On a hit with is_ret=0: `pred_taken`=1, `pred_target` = stored target.
- On a hit with is_ret=1: `pred_target` = RAS top if the RAS is non-empty, otherwise the stored target.
- `x_target` = x_pc + x_imm when `x_jop`=0; (x_rs1 + x_imm) & ~1 when `x_jop`=1. Modulo 2^XLEN; overflow is ignored.
- `x_mispredict` = `x_valid` & (!`x_pred_taken` | `x_pred_target` ≠ `x_target`). It is 0 when `x_valid`=0.
- Training happens when `x_valid`=1. At the clock edge, the entry indexed by `x_pc` is written with valid=1, the tag, `x_target` and `x_is_ret`. This happens whether or not the prediction was correct, and overwrites any aliasing entry.
- RAS is a circular buffer with `top` pointer and `count`. It is updated only when `x_valid`=1, in resolved program order; there is no speculative update.
- Call only: push x_pc+4. `top` wraps modulo RAS_DEPTH. On overflow the oldest entry is overwritten and `count` saturates at RAS_DEPTH.
- Ret only: pop. If the RAS is empty, nothing changes (no underflow).
- Call and ret together: replace top with x_pc+4. If the RAS is empty, this is a push.
- Lookup and training to the same index in the same cycle: the lookup returns pre-write contents. There is no bypass.

## Timing
- Lookup: 0-cycle, combinational from `f_pc`.
- Resolve outputs: 0-cycle, combinational from `x_*`.
- BTB/RAS writes are visible to lookups starting the cycle after the training edge.
- Reset values:
  - All BTB valid bits 0.
  - RAS `count`=0, `top`=0.
  - `pred_taken`=0 and `pred_target`=0 while reset is held, since nothing hits.
  - `x_*` outputs follow the inputs only.
- Reset asserted mid-stream takes effect immediately, asynchronously. A training write on the same edge is discarded.
- RAS data storage needs no reset; `count` gates its use.

## Configuration
- Macro: `JUMP_PRED_RAS_EN`.
- Defined: RAS is instantiated and behaves as above.
- Undefined:
  - No RAS storage.
  - is_ret entries predict the stored BTB target.
  - `x_is_call` and `x_is_ret` are ignored.
  - Port list is unchanged.

## Test plan
- Reset, then `f_pc`=0x100 → `pred_taken`=0, `pred_target`=0.
- JAL: x_pc=0x100, x_imm=0x40, x_jop=0, x_pred_taken=0 → `x_target`=0x140, `x_mispredict`=1. Next cycle, `f_pc`=0x100 → `pred_taken`=1, `pred_target`=0x140.
- JALR: x_rs1=0x2001, x_imm=0x2 → `x_target`=0x2002. Train it, replay with x_pred_target=0x2002 → `x_mispredict`=0.
- Alias: train 0x100 (target 0x140), then 0x140 with BTB_ENTRIES=16 (same index 0, different tag). `f_pc`=0x100 → miss. `f_pc`=0x140 → hit.
- With `JUMP_PRED_RAS_EN`: calls at 0x10, 0x20, 0x30, 0x40, 0x50 (RAS_DEPTH=4). Ret entry hits → targets 0x54, 0x44, 0x34, 0x24 on successive pops. Pop on empty → count stays 0 and the stored BTB target is predicted.
- Without `JUMP_PRED_RAS_EN`: same sequence → a ret hit always predicts the last trained `x_target`.

Source files
------------

// File: rtl/jump_predictor_if.sv
// Fetch/execute-side signal bundle of the jump target predictor.
// master drives f_pc and the resolving jump; slave is the predictor.
interface jump_predictor_if #(
    parameter int unsigned XLEN = 32
);
    logic [XLEN-1:0] f_pc;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            x_valid;
    logic            x_jop;
    logic [XLEN-1:0] x_pc;
    logic [XLEN-1:0] x_imm;
    logic [XLEN-1:0] x_rs1;
    logic            x_is_call;
    logic            x_is_ret;
    logic            x_pred_taken;
    logic [XLEN-1:0] x_pred_target;
    logic [XLEN-1:0] x_target;
    logic            x_mispredict;

    modport master (
        output f_pc, x_valid, x_jop, x_pc, x_imm, x_rs1, x_is_call, x_is_ret,
               x_pred_taken, x_pred_target,
        input  pred_taken, pred_target, x_target, x_mispredict
    );

    modport slave (
        input  f_pc, x_valid, x_jop, x_pc, x_imm, x_rs1, x_is_call, x_is_ret,
               x_pred_taken, x_pred_target,
        output pred_taken, pred_target, x_target, x_mispredict
    );
endinterface

// File: rtl/jump_predictor.sv
// JAL/JALR target predictor: direct-mapped BTB plus an optional return address stack,
// enabled by defining JUMP_PRED_RAS_EN.
module jump_predictor #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned BTB_ENTRIES = 16,
    parameter int unsigned RAS_DEPTH   = 4
) (
    input logic             clk,
    input logic             rst,
    jump_predictor_if.slave jp
);
    localparam int unsigned IDX  = $clog2(BTB_ENTRIES);
    localparam int unsigned TAGW = XLEN - IDX - 2;

    logic [BTB_ENTRIES-1:0] btb_valid;
    logic [BTB_ENTRIES-1:0] btb_is_ret;
    logic [TAGW-1:0]        btb_tag    [BTB_ENTRIES];
    logic [XLEN-2:0]        btb_target [BTB_ENTRIES];

    logic [IDX-1:0]  f_idx, x_idx;
    logic [TAGW-1:0] f_tag, x_tag;
    logic [XLEN-1:0] sum, target;
    logic            hit;
    logic            ras_avail;
    logic [XLEN-1:0] ras_top_val;
    logic            unused_pc_lsb;

    assign f_idx         = jp.f_pc[IDX+1:2];
    assign f_tag         = jp.f_pc[XLEN-1:IDX+2];
    assign x_idx         = jp.x_pc[IDX+1:2];
    assign x_tag         = jp.x_pc[XLEN-1:IDX+2];
    assign unused_pc_lsb = ^jp.f_pc[1:0];

    // Resolve
    always_comb begin
        sum    = jp.x_jop ? (jp.x_rs1 + jp.x_imm) : (jp.x_pc + jp.x_imm);
        target = sum;
        if (jp.x_jop) begin
            target[0] = 1'b0;
        end
    end

    assign jp.x_target     = target;
    assign jp.x_mispredict = jp.x_valid & (~jp.x_pred_taken | (jp.x_pred_target != target));

    // Lookup sees pre-write contents; no bypass from a same-cycle training write.
    assign hit = btb_valid[f_idx] && (btb_tag[f_idx] == f_tag);

    always_comb begin
        jp.pred_taken  = 1'b0;
        jp.pred_target = '0;
        if (hit) begin
            jp.pred_taken  = 1'b1;
            jp.pred_target = {btb_target[f_idx], 1'b0};
            if (btb_is_ret[f_idx] && ras_avail) begin
                jp.pred_target = ras_top_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btb_valid <= '0;
        end else if (jp.x_valid) begin
            btb_valid[x_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (jp.x_valid && !rst) begin
            btb_tag[x_idx]    <= x_tag;
            btb_target[x_idx] <= target[XLEN-1:1];
            btb_is_ret[x_idx] <= jp.x_is_ret;
        end
    end

`ifdef JUMP_PRED_RAS_EN
    localparam int unsigned RIDX = $clog2(RAS_DEPTH);
    localparam int unsigned CW   = $clog2(RAS_DEPTH + 1);

    logic [XLEN-1:0] ras_mem [RAS_DEPTH];
    logic [RIDX-1:0] top_q, top_d, wptr;
    logic [CW-1:0]   count_q, count_d;
    logic            ras_we;
    logic [XLEN-1:0] link;

    assign link        = jp.x_pc + XLEN'(4);
    assign ras_avail   = (count_q != '0);
    assign ras_top_val = ras_mem[top_q];

    always_comb begin
        top_d   = top_q;
        count_d = count_q;
        ras_we  = 1'b0;
        wptr    = top_q;
        if (jp.x_valid) begin
            if (jp.x_is_call && (!jp.x_is_ret || !ras_avail)) begin
                // Overflow overwrites the oldest slot; count saturates.
                top_d   = top_q + RIDX'(1);
                wptr    = top_q + RIDX'(1);
                ras_we  = 1'b1;
                count_d = (count_q == CW'(RAS_DEPTH)) ? count_q : count_q + CW'(1);
            end else if (jp.x_is_call && jp.x_is_ret) begin
                ras_we = 1'b1;
            end else if (jp.x_is_ret && ras_avail) begin
                top_d   = top_q - RIDX'(1);
                count_d = count_q - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top_q   <= '0;
            count_q <= '0;
        end else begin
            top_q   <= top_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (ras_we && !rst) begin
            ras_mem[wptr] <= link;
        end
    end
`else
    logic unused_cfg;

    assign ras_avail   = 1'b0;
    assign ras_top_val = '0;
    assign unused_cfg  = jp.x_is_call ^ RAS_DEPTH[0];
`endif
endmodule

// File: tb/tb_jump_predictor.sv
// Directed self-checking bench for jump_predictor; expectations follow JUMP_PRED_RAS_EN.
module tb_jump_predictor;
`ifdef JUMP_PRED_RAS_EN
    localparam bit RasEn = 1'b1;
`else
    localparam bit RasEn = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    jump_predictor_if #(.XLEN(32)) bus ();

    jump_predictor #(
        .XLEN       (32),
        .BTB_ENTRIES(16),
        .RAS_DEPTH  (4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .jp (bus)
    );

    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_x(input logic valid, input logic jop, input logic [31:0] pc,
                         input logic [31:0] imm, input logic [31:0] rs1, input logic call,
                         input logic ret, input logic ptaken, input logic [31:0] ptarget);
        bus.x_valid       = valid;
        bus.x_jop         = jop;
        bus.x_pc          = pc;
        bus.x_imm         = imm;
        bus.x_rs1         = rs1;
        bus.x_is_call     = call;
        bus.x_is_ret      = ret;
        bus.x_pred_taken  = ptaken;
        bus.x_pred_target = ptarget;
    endtask

    task automatic lookup(input string tag, input logic [31:0] pc, input logic taken,
                          input logic [31:0] target);
        bus.f_pc = pc;
        #1;
        check_eq({tag, ".taken"}, 32'(bus.pred_taken), 32'(taken));
        check_eq({tag, ".target"}, bus.pred_target, target);
    endtask

    // Pass one rising edge and return mid-low-phase with execute idle.
    task automatic clock_in();
        @(negedge clk);
        bus.x_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] links [4];
        logic [31:0] prev;
        links = '{32'h54, 32'h44, 32'h34, 32'h24};

        bus.f_pc = 32'h100;
        set_x(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #2;
        lookup("rst_held", 32'h100, 1'b0, 32'h0);
        check_eq("rst_xmis", 32'(bus.x_mispredict), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        lookup("rst_miss", 32'h100, 1'b0, 32'h0);

        // JAL train and hit next cycle
        set_x(1'b1, 1'b0, 32'h100, 32'h40, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("jal_tgt", bus.x_target, 32'h140);
        check_eq("jal_mis", 32'(bus.x_mispredict), 32'h1);
        clock_in();
        lookup("jal_hit", 32'h100, 1'b1, 32'h140);

        // JALR target clears bit 0
        set_x(1'b1, 1'b1, 32'h108, 32'h2, 32'h2001, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("jalr_tgt", bus.x_target, 32'h2002);
        check_eq("jalr_mis", 32'(bus.x_mispredict), 32'h1);
        clock_in();
        lookup("jalr_hit", 32'h108, 1'b1, 32'h2002);
        set_x(1'b1, 1'b1, 32'h108, 32'h2, 32'h2001, 1'b0, 1'b0, 1'b1, 32'h2002);
        #1;
        check_eq("jalr_ok", 32'(bus.x_mispredict), 32'h0);
        bus.x_pred_target = 32'h2000;
        #1;
        check_eq("jalr_badtgt", 32'(bus.x_mispredict), 32'h1);
        clock_in();

        // Alias at index 0; same-cycle lookup returns pre-write contents
        set_x(1'b1, 1'b0, 32'h140, 32'h10, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        lookup("nobypass", 32'h140, 1'b0, 32'h0);
        clock_in();
        lookup("alias_old", 32'h100, 1'b0, 32'h0);
        lookup("alias_new", 32'h140, 1'b1, 32'h150);

        // Target wraps modulo 2^32; x_valid=0 masks mispredict
        set_x(1'b0, 1'b0, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        #1;
        check_eq("wrap_tgt", bus.x_target, 32'h10);
        check_eq("novalid_mis", 32'(bus.x_mispredict), 32'h0);

        // Asynchronous reset mid-cycle; training on the reset edge is dropped
        bus.f_pc = 32'h140;
        rst = 1'b1;
        #1;
        check_eq("async_rst", 32'(bus.pred_taken), 32'h0);
        set_x(1'b1, 1'b0, 32'h104, 32'h8, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);
        clock_in();
        rst = 1'b0;
        lookup("rst_drop", 32'h104, 1'b0, 32'h0);
        lookup("rst_clr", 32'h108, 1'b0, 32'h0);

        // Return entry trained while RAS is empty
        set_x(1'b1, 1'b1, 32'h20C, 32'h0, 32'h800, 1'b0, 1'b1, 1'b0, 32'h0);
        clock_in();
        lookup("ret_init", 32'h20C, 1'b1, 32'h800);

        for (int i = 1; i <= 5; i++) begin
            set_x(1'b1, 1'b0, 32'(i * 16), 32'h1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
            clock_in();
        end

        prev = 32'h800;
        for (int k = 0; k < 4; k++) begin
            lookup($sformatf("ret_pop%0d", k), 32'h20C, 1'b1, RasEn ? links[k] : prev);
            set_x(1'b1, 1'b1, 32'h20C, 32'h0, links[k], 1'b0, 1'b1, 1'b1, links[k]);
            clock_in();
            prev = links[k];
        end
        lookup("ras_empty", 32'h20C, 1'b1, 32'h24);

        set_x(1'b1, 1'b1, 32'h20C, 32'h0, 32'h900, 1'b0, 1'b1, 1'b1, 32'h24);
        clock_in();
        lookup("pop_empty", 32'h20C, 1'b1, 32'h900);

        set_x(1'b1, 1'b0, 32'h60, 32'h1000, 32'h0, 1'b1, 1'b0, 1'b0, 32'h0);
        clock_in();
        lookup("push_after", 32'h20C, 1'b1, RasEn ? 32'h64 : 32'h900);

        set_x(1'b1, 1'b1, 32'h70, 32'h0, 32'h3000, 1'b1, 1'b1, 1'b0, 32'h0);
        clock_in();
        lookup("call_ret", 32'h20C, 1'b1, RasEn ? 32'h74 : 32'h900);

        set_x(1'b1, 1'b1, 32'h20C, 32'h0, 32'hA00, 1'b0, 1'b1, 1'b1, 32'h74);
        clock_in();
        lookup("replace_cnt", 32'h20C, 1'b1, 32'hA00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
